// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the tile VRAM word array and shares its single port
// between the CPU data bus and the VGA tile fetcher. Video always wins the
// port; CPU writes are posted into a one-entry buffer and CPU reads wait for
// a free port. Cycles in which video blocks the CPU are counted for debug.
// The word array has no reset; its contents start at zero from configuration.
module vram_arbiter #(
    parameter int DEPTH      = 126,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    input  logic [3:0]            cpu_wstrb_i,
    output logic                  cpu_ready_o,
    output logic [31:0]           cpu_rdata_o,
    input  logic                  vid_req_i,
    input  logic [ADDR_WIDTH-1:0] vid_addr_i,
    output logic                  vid_valid_o,
    output logic [31:0]           vid_rdata_o,
    output logic [15:0]           conflict_count_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } cpuState_e;

    logic [31:0]           mem_q [DEPTH];

    cpuState_e             state_q, state_d;
    logic                  wbValid_q, wbValid_d;
    logic [ADDR_WIDTH-1:0] wbAddr_q, wbAddr_d;
    logic [31:0]           wbData_q, wbData_d;
    logic [3:0]            wbStrb_q, wbStrb_d;
    logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
    logic [31:0]           cpuRdata_q, cpuRdata_d;
    logic                  vidValid_q, vidValid_d;
    logic [31:0]           vidRdata_q, vidRdata_d;
    logic [15:0]           conflict_q, conflict_d;

    logic                  drain;
    logic                  portFree;
    logic                  readIssue;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic [ADDR_WIDTH-1:0] portAddr;
    logic [31:0]           memWord;
    logic [31:0]           vidWord;
    logic                  memWe;
    logic                  conflictHit;

    // Addresses at or above DEPTH do not exist: writes are dropped, reads give 0.
    function automatic logic inRange(input logic [ADDR_WIDTH-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Port arbitration, write-buffer bookkeeping and CPU next-state logic.
    always_comb begin
        drain     = wbValid_q && !vid_req_i;
        portFree  = !vid_req_i && !wbValid_q;
        state_d   = state_q;
        wbValid_d = wbValid_q;
        wbAddr_d  = wbAddr_q;
        wbData_d  = wbData_q;
        wbStrb_d  = wbStrb_q;
        rdAddr_d  = rdAddr_q;
        readIssue = 1'b0;
        readAddr  = cpu_addr_i;

        if (drain) begin
            wbValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        if (!wbValid_q || drain) begin
                            wbValid_d = 1'b1;
                            wbAddr_d  = cpu_addr_i;
                            wbData_d  = cpu_wdata_i;
                            wbStrb_d  = cpu_wstrb_i;
                            state_d   = ACK;
                        end
                    end else if (portFree) begin
                        readIssue = 1'b1;
                        readAddr  = cpu_addr_i;
                        state_d   = ACK;
                    end else begin
                        rdAddr_d = cpu_addr_i;
                        state_d  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (portFree) begin
                    readIssue = 1'b1;
                    readAddr  = rdAddr_q;
                    state_d   = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single memory port: one address per cycle, video first, then the drain.
    always_comb begin
        if (vid_req_i) begin
            portAddr = vid_addr_i;
        end else if (drain) begin
            portAddr = wbAddr_q;
        end else begin
            portAddr = readAddr;
        end
        memWord = inRange(portAddr) ? mem_q[portAddr] : 32'h0;
        memWe   = drain && rst_n_i && inRange(wbAddr_q);
    end

    // Video sees a pending buffered write to its address merged into the word.
    always_comb begin
        vidWord = memWord;
        if (wbValid_q && (wbAddr_q == vid_addr_i) && inRange(vid_addr_i)) begin
            for (int b = 0; b < 4; b++) begin
                if (wbStrb_q[b]) begin
                    vidWord[8*b +: 8] = wbData_q[8*b +: 8];
                end
            end
        end
    end

    // Read-data capture and the saturating contention counter.
    always_comb begin
        cpuRdata_d  = readIssue ? memWord : cpuRdata_q;
        vidValid_d  = vid_req_i;
        vidRdata_d  = vid_req_i ? vidWord : vidRdata_q;
        conflictHit = vid_req_i &&
                      ((state_q == RD_WAIT) ||
                       ((state_q == IDLE) && cpu_req_i && !cpu_we_i) ||
                       wbValid_q);
        conflict_d  = (conflictHit && (conflict_q != 16'hFFFF)) ? conflict_q + 16'd1
                                                                 : conflict_q;
    end

    // Control and output registers; reset drops any outstanding CPU work.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            wbValid_q  <= 1'b0;
            wbAddr_q   <= '0;
            wbData_q   <= '0;
            wbStrb_q   <= '0;
            rdAddr_q   <= '0;
            cpuRdata_q <= '0;
            vidValid_q <= 1'b0;
            vidRdata_q <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            wbValid_q  <= wbValid_d;
            wbAddr_q   <= wbAddr_d;
            wbData_q   <= wbData_d;
            wbStrb_q   <= wbStrb_d;
            rdAddr_q   <= rdAddr_d;
            cpuRdata_q <= cpuRdata_d;
            vidValid_q <= vidValid_d;
            vidRdata_q <= vidRdata_d;
            conflict_q <= conflict_d;
        end
    end

    // Byte-strobed write of the draining buffer entry into the word array.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (wbStrb_q[b]) begin
                    mem_q[wbAddr_q][8*b +: 8] <= wbData_q[8*b +: 8];
                end
            end
        end
    end

    assign cpu_ready_o      = (state_q == ACK);
    assign cpu_rdata_o      = cpuRdata_q;
    assign vid_valid_o      = vidValid_q;
    assign vid_rdata_o      = vidRdata_q;
    assign conflict_count_o = conflict_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cpuReq;
    logic        cpuWe;
    logic [6:0]  cpuAddr;
    logic [31:0] cpuWdata;
    logic [3:0]  cpuWstrb;
    logic        cpuReady;
    logic [31:0] cpuRdata;
    logic        vidReq;
    logic [6:0]  vidAddr;
    logic        vidValid;
    logic [31:0] vidRdata;
    logic [15:0] conflictCount;

    int total = 0;
    int bad   = 0;
    int lat;

    vram_arbiter #(.DEPTH(126), .ADDR_WIDTH(7)) dut (
        .clk_i           (clk),
        .rst_n_i         (rstN),
        .cpu_req_i       (cpuReq),
        .cpu_we_i        (cpuWe),
        .cpu_addr_i      (cpuAddr),
        .cpu_wdata_i     (cpuWdata),
        .cpu_wstrb_i     (cpuWstrb),
        .cpu_ready_o     (cpuReady),
        .cpu_rdata_o     (cpuRdata),
        .vid_req_i       (vidReq),
        .vid_addr_i      (vidAddr),
        .vid_valid_o     (vidValid),
        .vid_rdata_o     (vidRdata),
        .conflict_count_o(conflictCount)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one CPU access, wait (bounded) for cpu_ready, then step past ACK.
    task automatic applyStimulus(input logic we, input logic [6:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output int cycles);
        cpuReq   = 1'b1;
        cpuWe    = we;
        cpuAddr  = addr;
        cpuWdata = data;
        cpuWstrb = strb;
        cycles   = 0;
        do begin
            tick();
            cycles++;
        end while (!cpuReady && cycles < 20);
        cpuReq = 1'b0;
        cpuWe  = 1'b0;
        tick();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0;
        cpuWdata = '0; cpuWstrb = '0; vidReq = 1'b0; vidAddr = '0;
        tick();
        tick();
        checkOutput("rst ready",    {31'd0, cpuReady}, 32'd0);
        checkOutput("rst rdata",    cpuRdata, 32'd0);
        checkOutput("rst vidvalid", {31'd0, vidValid}, 32'd0);
        checkOutput("rst vidrdata", vidRdata, 32'd0);
        checkOutput("rst conflict", {16'd0, conflictCount}, 32'd0);
        rstN = 1'b1;
        tick();

        $display("[TB] write then read");
        applyStimulus(1'b1, 7'd5, 32'hDEADBEEF, 4'hF, lat);
        checkOutput("wr5 latency", lat, 32'd1);
        applyStimulus(1'b0, 7'd5, 32'h0, 4'h0, lat);
        checkOutput("rd5 latency", lat, 32'd1);
        checkOutput("rd5 data", cpuRdata, 32'hDEADBEEF);

        $display("[TB] byte strobe");
        applyStimulus(1'b1, 7'd3, 32'h11223344, 4'hF, lat);
        applyStimulus(1'b1, 7'd3, 32'hAABBCCDD, 4'b0101, lat);
        applyStimulus(1'b0, 7'd3, 32'h0, 4'h0, lat);
        checkOutput("strb data", cpuRdata, 32'h11BB33DD);

        $display("[TB] video blocks cpu read");
        applyStimulus(1'b1, 7'd0, 32'hCAFE0000, 4'hF, lat);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 7'd0;
        vidReq = 1'b1; vidAddr = 7'd5;
        tick();
        checkOutput("blk ready1", {31'd0, cpuReady}, 32'd0);
        checkOutput("blk vvalid1", {31'd0, vidValid}, 32'd1);
        checkOutput("blk vdata1", vidRdata, 32'hDEADBEEF);
        vidAddr = 7'd3;
        tick();
        checkOutput("blk ready2", {31'd0, cpuReady}, 32'd0);
        checkOutput("blk vdata2", vidRdata, 32'h11BB33DD);
        vidAddr = 7'd0;
        tick();
        checkOutput("blk ready3", {31'd0, cpuReady}, 32'd0);
        checkOutput("blk vdata3", vidRdata, 32'hCAFE0000);
        vidReq = 1'b0;
        tick();
        checkOutput("blk ready4", {31'd0, cpuReady}, 32'd1);
        checkOutput("blk rdata", cpuRdata, 32'hCAFE0000);
        checkOutput("blk vvalid4", {31'd0, vidValid}, 32'd0);
        checkOutput("blk vhold", vidRdata, 32'hCAFE0000);
        checkOutput("blk conflict", {16'd0, conflictCount}, 32'd3);
        cpuReq = 1'b0;
        tick();

        $display("[TB] forwarding and full buffer");
        applyStimulus(1'b1, 7'd9, 32'h0BADF00D, 4'hF, lat);
        vidReq = 1'b1; vidAddr = 7'd5;
        applyStimulus(1'b1, 7'd9, 32'h12345678, 4'hF, lat);
        checkOutput("fwd wr latency", lat, 32'd1);
        vidAddr = 7'd9;
        tick();
        checkOutput("fwd vdata", vidRdata, 32'h12345678);
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 7'd9;
        cpuWdata = 32'hAAAAAA99; cpuWstrb = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("full ready", {31'd0, cpuReady}, 32'd0);
        end
        checkOutput("full vdata", vidRdata, 32'h12345678);
        vidReq = 1'b0;
        tick();
        checkOutput("full ready drain", {31'd0, cpuReady}, 32'd1);
        cpuReq = 1'b0; cpuWe = 1'b0;
        tick();
        checkOutput("full conflict", {16'd0, conflictCount}, 32'd8);
        applyStimulus(1'b0, 7'd9, 32'h0, 4'h0, lat);
        checkOutput("full order data", cpuRdata, 32'h12345699);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 7'd20, 32'h55555555, 4'hF, lat);
        vidReq = 1'b1; vidAddr = 7'd5;
        applyStimulus(1'b1, 7'd20, 32'h77777777, 4'hF, lat);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 7'd20;
        tick();
        checkOutput("mid rdwait1", {31'd0, cpuReady}, 32'd0);
        tick();
        checkOutput("mid rdwait2", {31'd0, cpuReady}, 32'd0);
        rstN = 1'b0;
        tick();
        checkOutput("mid ready", {31'd0, cpuReady}, 32'd0);
        checkOutput("mid rdata", cpuRdata, 32'd0);
        checkOutput("mid vvalid", {31'd0, vidValid}, 32'd0);
        checkOutput("mid vdata", vidRdata, 32'd0);
        checkOutput("mid conflict", {16'd0, conflictCount}, 32'd0);
        rstN = 1'b1; cpuReq = 1'b0; vidReq = 1'b0;
        tick();
        applyStimulus(1'b0, 7'd20, 32'h0, 4'h0, lat);
        checkOutput("mid rd latency", lat, 32'd1);
        checkOutput("mid wr dropped", cpuRdata, 32'h55555555);

        $display("[TB] out-of-range addresses");
        applyStimulus(1'b1, 7'd126, 32'hFFFFFFFF, 4'hF, lat);
        applyStimulus(1'b0, 7'd126, 32'h0, 4'h0, lat);
        checkOutput("oor cpu rd", cpuRdata, 32'd0);
        vidReq = 1'b1; vidAddr = 7'd126;
        tick();
        checkOutput("oor vid valid", {31'd0, vidValid}, 32'd1);
        checkOutput("oor vid rd", vidRdata, 32'd0);
        vidAddr = 7'd5;
        tick();
        checkOutput("vid rd5", vidRdata, 32'hDEADBEEF);
        vidReq = 1'b0;
        tick();
        checkOutput("vid idle valid", {31'd0, vidValid}, 32'd0);
        checkOutput("vid idle hold", vidRdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
